// File: rtl/ram_arbiter.sv
// ram_arbiter: shares RAM port A between the CPU (absolute priority, ROM write-protect)
// and a level-held SPI loader request that fills the gaps between CPU slots.
module ram_arbiter #(
  parameter bit WP_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_slot,
  input  logic        cpu_halt,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_wdata,
  input  logic        spi_req,
  input  logic        spi_we,
  input  logic [15:0] spi_addr,
  input  logic [7:0]  spi_wdata,
  output logic        spi_busy,
  output logic        spi_done,
  output logic [7:0]  spi_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        cpu_rdata_valid,
  output logic        wp_hit
);
  typedef enum logic [1:0] {IDLE, PEND, ISSUE, CAPT} state_t;
  state_t      state;
  logic        buf_we;
  logic [15:0] buf_addr;
  logic [7:0]  buf_wdata;
  logic        cpu_v1;
  logic        cpu_go;
  logic        prot;
  assign cpu_go = cpu_slot & ~cpu_halt;
  // char ROM 0x8000-0x8FFF and BASIC/KERNAL 0xC000-0xFFFF
  assign prot = WP_EN & ((cpu_addr[15:12] == 4'h8) | (cpu_addr[15:14] == 2'b11));
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      buf_we          <= 1'b0;
      buf_addr        <= 16'h0000;
      buf_wdata       <= 8'h00;
      spi_busy        <= 1'b0;
      spi_done        <= 1'b0;
      spi_rdata       <= 8'h00;
      mem_addr        <= 16'h0000;
      mem_we          <= 1'b0;
      mem_wdata       <= 8'h00;
      cpu_v1          <= 1'b0;
      cpu_rdata_valid <= 1'b0;
      wp_hit          <= 1'b0;
    end else begin
      mem_we          <= 1'b0;
      wp_hit          <= 1'b0;
      spi_done        <= 1'b0;
      cpu_v1          <= cpu_go;
      cpu_rdata_valid <= cpu_v1;
      case (state)
        IDLE: if (spi_req) begin
          buf_we    <= spi_we;
          buf_addr  <= spi_addr;
          buf_wdata <= spi_wdata;
          spi_busy  <= 1'b1;
          state     <= PEND;
        end
        PEND: if (!cpu_go) begin
          mem_addr  <= buf_addr;
          mem_wdata <= buf_wdata;
          mem_we    <= buf_we;
          state     <= ISSUE;
        end
        ISSUE: state <= CAPT;
        CAPT: begin
          spi_rdata <= buf_we ? spi_rdata : mem_rdata;
          spi_done  <= 1'b1;
          spi_busy  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // the loader only issues when cpu_go is low, so this never collides
      if (cpu_go) begin
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
        mem_we    <= cpu_we & ~prot;
        wp_hit    <= cpu_we & prot;
      end
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: vector table for CPU issue/protect/hold behaviour plus directed
// loader sequences against a synchronous RAM model.
module tb_ram_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_slot, cpu_halt, cpu_we, spi_req, spi_we;
  logic [15:0] cpu_addr, spi_addr, mem_addr;
  logic [7:0]  cpu_wdata, spi_wdata, spi_rdata, mem_wdata, mem_rdata;
  logic        spi_busy, spi_done, mem_we, cpu_rdata_valid, wp_hit;
  logic [7:0]  ram [0:65535];
  int checks = 0;
  int errors = 0;

  ram_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_slot(cpu_slot), .cpu_halt(cpu_halt), .cpu_addr(cpu_addr),
    .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .spi_req(spi_req), .spi_we(spi_we), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
    .spi_busy(spi_busy), .spi_done(spi_done), .spi_rdata(spi_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cpu_rdata_valid(cpu_rdata_valid), .wp_hit(wp_hit)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    logic        slot, halt;
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wd;
    logic [15:0] e_addr;
    logic        e_we;
    logic [7:0]  e_wd;
    logic        e_wp, e_v;
  } vec_t;
  vec_t tv [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n, last, bad, dn;
    logic [7:0] rd;
    tv[0] = '{1'b1, 1'b0, 16'h1E00, 1'b1, 8'h41, 16'h1E00, 1'b1, 8'h41, 1'b0, 1'b0};
    tv[1] = '{1'b1, 1'b0, 16'hC123, 1'b1, 8'h55, 16'hC123, 1'b0, 8'h55, 1'b1, 1'b1};
    tv[2] = '{1'b1, 1'b0, 16'h8FFF, 1'b1, 8'h12, 16'h8FFF, 1'b0, 8'h12, 1'b1, 1'b1};
    tv[3] = '{1'b1, 1'b0, 16'h9000, 1'b1, 8'h34, 16'h9000, 1'b1, 8'h34, 1'b0, 1'b1};
    tv[4] = '{1'b1, 1'b0, 16'h7FFF, 1'b1, 8'h56, 16'h7FFF, 1'b1, 8'h56, 1'b0, 1'b1};
    tv[5] = '{1'b1, 1'b0, 16'hBFFF, 1'b1, 8'h78, 16'hBFFF, 1'b1, 8'h78, 1'b0, 1'b1};
    tv[6] = '{1'b0, 1'b0, 16'h1234, 1'b1, 8'h99, 16'hBFFF, 1'b0, 8'h78, 1'b0, 1'b1};
    tv[7] = '{1'b1, 1'b1, 16'h2222, 1'b1, 8'h99, 16'hBFFF, 1'b0, 8'h78, 1'b0, 1'b0};
    tv[8] = '{1'b1, 1'b0, 16'h8000, 1'b0, 8'hAA, 16'h8000, 1'b0, 8'hAA, 1'b0, 1'b0};
    tv[9] = '{1'b1, 1'b0, 16'hFFFF, 1'b1, 8'h01, 16'hFFFF, 1'b0, 8'h01, 1'b1, 1'b1};
    reset_n = 1'b0;
    {cpu_slot, cpu_halt, cpu_we, spi_req, spi_we} = '0;
    cpu_addr = 16'h0; cpu_wdata = 8'h0; spi_addr = 16'h0; spi_wdata = 8'h0;
    #1;
    chk("reset_outputs", {spi_busy, spi_done, spi_rdata, mem_we, cpu_rdata_valid, wp_hit}, 32'h0);
    chk("reset_mem", {mem_addr, mem_wdata}, 32'h0);
    step; step;
    reset_n = 1'b1;
    cpu_slot = 1'b1; cpu_addr = 16'h0042;
    step;
    chk("first_edge_slot", mem_addr, 32'h0042);
    chk("valid_not_yet", cpu_rdata_valid, 1'b0);
    cpu_slot = 1'b0;
    step;
    chk("valid_two_cycles", cpu_rdata_valid, 1'b1);
    step;
    chk("valid_one_pulse", cpu_rdata_valid, 1'b0);

    for (int i = 0; i < 10; i++) begin
      cpu_slot = tv[i].slot; cpu_halt = tv[i].halt; cpu_addr = tv[i].addr;
      cpu_we = tv[i].we; cpu_wdata = tv[i].wd;
      step;
      chk($sformatf("vec%0d_addr", i), mem_addr, tv[i].e_addr);
      chk($sformatf("vec%0d_we", i), mem_we, tv[i].e_we);
      chk($sformatf("vec%0d_wdata", i), mem_wdata, tv[i].e_wd);
      chk($sformatf("vec%0d_wp", i), wp_hit, tv[i].e_wp);
      chk($sformatf("vec%0d_valid", i), cpu_rdata_valid, tv[i].e_v);
    end
    {cpu_slot, cpu_halt, cpu_we} = '0;
    step; step;

    // loader write of 0x0E to 0x9400
    spi_req = 1'b1; spi_we = 1'b1; spi_addr = 16'h9400; spi_wdata = 8'h0E;
    step;
    chk("wr_busy_set", spi_busy, 1'b1);
    step;
    chk("wr_issue", {mem_addr, mem_wdata, 7'h0, mem_we}, {16'h9400, 8'h0E, 8'h01});
    step;
    chk("wr_capt_no_done", spi_done, 1'b0);
    step;
    chk("wr_done", {spi_done, spi_busy}, 2'b10);
    spi_req = 1'b0;
    step;
    chk("wr_done_pulse", {spi_done, spi_busy}, 2'b00);

    // loader read of 0x9400 with a CPU slot arriving one cycle later
    spi_req = 1'b1; spi_we = 1'b0;
    step;
    chk("rd_pend_busy", spi_busy, 1'b1);
    cpu_slot = 1'b1; cpu_addr = 16'h0100; cpu_we = 1'b0;
    step;
    chk("rd_cpu_first", mem_addr, 32'h0100);
    chk("rd_still_busy", spi_busy, 1'b1);
    cpu_slot = 1'b0;
    step;
    chk("rd_spi_issue", {mem_addr, 7'h0, mem_we}, {16'h9400, 8'h00});
    step;
    step;
    chk("rd_done", spi_done, 1'b1);
    chk("rd_data", spi_rdata, 8'h0E);
    spi_req = 1'b0;
    step;

    // loader write into ROM range is not protected; spi_rdata holds
    spi_req = 1'b1; spi_we = 1'b1; spi_addr = 16'hC123; spi_wdata = 8'h77;
    step;
    step;
    chk("spi_rom_we", {mem_addr, 7'h0, mem_we}, {16'hC123, 8'h01});
    chk("spi_rom_no_wp", wp_hit, 1'b0);
    step;
    step;
    chk("spi_rom_done", spi_done, 1'b1);
    chk("spi_rdata_held", spi_rdata, 8'h0E);
    spi_req = 1'b0;
    step;
    chk("spi_rom_ram", ram[16'hC123], 8'h77);

    // CPU halted: 16 back-to-back loader writes
    cpu_halt = 1'b1; cpu_slot = 1'b1; cpu_addr = 16'h5555; cpu_we = 1'b1;
    spi_req = 1'b1; spi_we = 1'b1; spi_addr = 16'h3000; spi_wdata = 8'h80;
    n = 0; last = 0; bad = 0;
    for (int c = 0; c < 100 && n < 16; c++) begin
      step;
      if (cpu_rdata_valid || mem_addr == 16'h5555) bad++;
      if (spi_done) begin
        if (n > 0 && c - last != 4) bad++;
        last = c;
        n++;
        spi_addr = 16'h3000 + 16'(n); spi_wdata = 8'h80 + 8'(n);
        if (n == 16) spi_req = 1'b0;
      end
    end
    chk("halt_done_count", n, 16);
    chk("halt_spacing_no_cpu", bad, 0);
    chk("halt_last_write", ram[16'h300F], 8'h8F);
    cpu_halt = 1'b0; cpu_slot = 1'b0; cpu_we = 1'b0;
    step;

    // reset while PEND
    spi_req = 1'b1; spi_we = 1'b0; spi_addr = 16'h3005;
    step;
    chk("rst_pend_busy", spi_busy, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_ctrl", {spi_busy, spi_done, spi_rdata, mem_we, cpu_rdata_valid, wp_hit}, 32'h0);
    chk("rst_async_mem", {mem_addr, mem_wdata}, 32'h0);
    spi_req = 1'b0;
    step;
    reset_n = 1'b1;
    dn = 0;
    for (int c = 0; c < 6; c++) begin
      step;
      if (spi_done || spi_busy) dn++;
    end
    chk("rst_no_done", dn, 0);

    // request dropped while PEND still completes exactly once
    spi_req = 1'b1; spi_we = 1'b0; spi_addr = 16'h300F;
    step;
    spi_req = 1'b0;
    dn = 0; rd = 8'h00;
    for (int c = 0; c < 10; c++) begin
      step;
      if (spi_done) begin dn++; rd = spi_rdata; end
    end
    chk("drop_done_once", dn, 1);
    chk("drop_rdata", rd, 8'h8F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter WP_EN, default 1: 1 = CPU writes to ROM ranges are suppressed.
REQ-002 clk  in  1  system clock (25 MHz domain); all state changes on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 cpu_slot  in  1  one-cycle strobe marking a CPU access cycle (cpu_clken).
REQ-005 cpu_halt  in  1  1 = CPU held; cpu_slot is ignored.
REQ-006 cpu_addr  in  16; cpu_we  in  1; cpu_wdata  in  8: CPU request fields, sampled only with cpu_slot.
REQ-007 spi_req  in  1; spi_we  in  1; spi_addr  in  16; spi_wdata  in  8: loader request, level-held until spi_done.
REQ-008 spi_busy  out  1: loader request captured and not yet completed.
REQ-009 spi_done  out  1: one-cycle completion pulse.
REQ-010 spi_rdata  out  8: read data, valid with spi_done and held until the next spi_done.
REQ-011 mem_addr  out  16; mem_we  out  1; mem_wdata  out  8: registered RAM port A drive.
REQ-012 mem_rdata  in  8: RAM port A synchronous read data, valid one cycle after mem_addr is presented.
REQ-013 cpu_rdata_valid  out  1: pulse two cycles after an accepted cpu_slot.
REQ-014 wp_hit  out  1: pulse, same cycle as the suppressed issue, when a CPU write is blocked.

Function
REQ-015 The CPU has absolute priority: on an edge with cpu_slot=1 and cpu_halt=0, the block registers mem_addr=cpu_addr, mem_wdata=cpu_wdata and mem_we=cpu_we&~prot.
REQ-016 prot = WP_EN & (cpu_addr[15:12]==4'h8 | cpu_addr[15:14]==2'b11), covering char ROM 0x8000-0x8FFF and BASIC/KERNAL 0xC000-0xFFFF.
REQ-017 Protected CPU writes issue with mem_we=0 and pulse wp_hit; SPI writes are never protected.
REQ-018 In cycles with no issue, mem_we is 0 and mem_addr/mem_wdata hold their last values.
REQ-019 The loader FSM has four states: IDLE, PEND, ISSUE and CAPT.
REQ-020 IDLE->PEND on spi_req=1: spi_we/addr/wdata are copied into the buffer and spi_busy is set in the same edge.
REQ-021 PEND->ISSUE on the first edge where no CPU issue is occurring (cpu_slot=0 or cpu_halt=1): buffer driven onto mem_*; mem_we=buffer we.
REQ-022 PEND stays in PEND while the CPU wins the slot; there is no bound on wait other than CPU slot rate (max 1 in 25 cycles at 1 MHz).
REQ-023 ISSUE->CAPT unconditionally; the RAM samples in this cycle.
REQ-024 CAPT->IDLE: spi_rdata <= mem_rdata for reads (unchanged for writes), spi_done pulses 1 cycle, and spi_busy clears.
REQ-025 spi_req still high in the cycle after spi_done is taken as a new request, so back-to-back loader access is 4 cycles minimum.
REQ-026 A cpu_slot arriving while in ISSUE or CAPT wins the port on that edge.
REQ-027 ISSUE is one edge only, so it cannot overlap a CPU issue; the RAM has a one-deep pipeline, so CAPT data remains the SPI read.
REQ-028 With cpu_halt=1, cpu_rdata_valid stays 0, and pending loader requests issue on the next edge.
REQ-029 cpu_rdata_valid pulses 2 edges after each accepted cpu_slot, including protected writes.
REQ-030 spi_req deasserted while in PEND does not cancel the access; the buffered access still completes.

Reset
REQ-031 When reset_n=0, asynchronously: state=IDLE, spi_busy=0, spi_done=0, spi_rdata=8'h00, mem_addr=16'h0000, mem_we=0, mem_wdata=8'h00, cpu_rdata_valid=0, wp_hit=0.
REQ-032 Reset mid-operation discards the buffered loader access, and no spi_done is produced for it.
REQ-033 After reset release, the first edge is treated as normal and a cpu_slot there is accepted.

Verification
REQ-034 cpu_slot, addr 0x1E00, we=1, data 0x41 -> next edge mem_addr=0x1E00, mem_we=1, mem_wdata=0x41; cpu_rdata_valid pulses 2 edges after the slot.
REQ-035 CPU write to 0xC123 with WP_EN=1 -> mem_we=0 and wp_hit=1; the same write via SPI -> mem_we=1.
REQ-036 SPI read of 0x9400 (RAM holds 0x0E), spi_req raised 1 cycle before cpu_slot -> the CPU issues first, the SPI issues one edge later, and spi_done arrives with spi_rdata=0x0E.
REQ-037 cpu_halt=1 with 16 back-to-back SPI writes -> 16 spi_done pulses, 4 cycles apart, and no CPU issues.
REQ-038 reset_n pulled low during PEND -> all outputs reach their reset values immediately, with no spi_done, and spi_busy=0 after release.
REQ-039 spi_req dropped in PEND -> the access still issues and spi_done pulses exactly once.
